// File: rtl/log_accumulator.sv
// Serial log-domain reducer: folds z lanes per beat, accumulates beats
// until in_last, then offers the sum over a valid/ready handshake.
module log_accumulator #(
  parameter int z        = 4,
  parameter int width    = 16,
  parameter int int_bits = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [width*z-1:0] in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [width-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sat
);

  localparam int M  = width - 1;
  localparam int F  = width - 1 - int_bits;
  localparam int LW = (z > 1) ? $clog2(z) : 1;

  typedef enum logic [1:0] {
    IDLE, FOLD, HOLD, OUT
  } state_e;

  state_e             state_q;
  logic [width*z-1:0] beat_q;
  logic               last_q;
  logic               first_q;
  logic [LW-1:0]      lane_q;
  logic [width-1:0]   acc_q;
  logic               sat_q;

  logic [width-1:0] lane_w;
  logic [M-1:0]     ma, mx;
  logic [M-1:0]     big_m, small_m;
  logic [M-1:0]     d, k, cf;
  logic [M:0]       sum;
  logic             big_s, swap;
  logic [width-1:0] add_d;
  logic             add_sat;

  always_comb begin
    lane_w = '0;
    for (int i = 0; i < z; i++) begin
      if (lane_q == LW'(i)) begin
        lane_w = beat_q[i*width +: width];
      end
    end
  end

  // Tie on magnitude keeps the accumulator as the big operand.
  always_comb begin
    ma      = acc_q[M-1:0];
    mx      = lane_w[M-1:0];
    swap    = mx > ma;
    big_m   = swap ? mx : ma;
    small_m = swap ? ma : mx;
    big_s   = swap ? lane_w[M] : acc_q[M];
    d       = big_m - small_m;
    k       = d >> F;
    cf      = (k > M'(F)) ? '0 : ((M'(1) << F) >> k);
    sum     = {1'b0, big_m} + {1'b0, cf};
    add_sat = 1'b0;
    if (acc_q[M] == lane_w[M]) begin
      if (sum[M]) begin
        add_d   = {big_s, {M{1'b1}}};
        add_sat = 1'b1;
      end else begin
        add_d = {big_s, sum[M-1:0]};
      end
    end else if (cf > big_m) begin
      add_d = {big_s, {M{1'b0}}};
    end else begin
      add_d = {big_s, big_m - cf};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      last_q  <= 1'b0;
      first_q <= 1'b0;
      lane_q  <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            beat_q  <= in_data;
            last_q  <= in_last;
            first_q <= 1'b1;
            sat_q   <= 1'b0;
            lane_q  <= '0;
            state_q <= FOLD;
          end
        end
        FOLD: begin
          if (first_q) begin
            acc_q   <= lane_w;
            first_q <= 1'b0;
          end else begin
            acc_q <= add_d;
            sat_q <= sat_q | add_sat;
          end
          if (lane_q == LW'(z - 1)) begin
            lane_q  <= '0;
            state_q <= last_q ? OUT : HOLD;
          end else begin
            lane_q <= lane_q + LW'(1);
          end
        end
        HOLD: begin
          if (in_valid) begin
            beat_q  <= in_data;
            last_q  <= in_last;
            first_q <= 1'b0;
            lane_q  <= '0;
            state_q <= FOLD;
          end
        end
        OUT: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) || (state_q == HOLD);
  assign out_valid = (state_q == OUT);
  assign out_data  = acc_q;
  assign out_sat   = sat_q;

endmodule

// File: tb/tb_log_accumulator.sv
// Directed bench for log_accumulator: z=4 vector table plus
// z=2 cancel/saturate cases and multi-cycle corner sequences.
module tb_log_accumulator;

  logic        clk = 1'b0;
  logic        reset;

  logic [63:0] in_data4;
  logic        in_valid4, in_last4, in_ready4;
  logic [15:0] out_data4;
  logic        out_valid4, out_ready4, out_sat4;

  logic [31:0] in_data2;
  logic        in_valid2, in_last2, in_ready2;
  logic [15:0] out_data2;
  logic        out_valid2, out_ready2, out_sat2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  log_accumulator #(.z(4), .width(16), .int_bits(5)) u4 (
    .clk(clk), .reset(reset),
    .in_data(in_data4), .in_valid(in_valid4),
    .in_last(in_last4), .in_ready(in_ready4),
    .out_data(out_data4), .out_valid(out_valid4),
    .out_ready(out_ready4), .out_sat(out_sat4)
  );

  log_accumulator #(.z(2), .width(16), .int_bits(5)) u2 (
    .clk(clk), .reset(reset),
    .in_data(in_data2), .in_valid(in_valid2),
    .in_last(in_last2), .in_ready(in_ready2),
    .out_data(out_data2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_sat(out_sat2)
  );

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic [15:0] exp;
    logic        esat;
  } vec_t;

  vec_t tbl [9];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send4(logic [63:0] d, logic l);
    bit ok = 0;
    in_data4  = d;
    in_last4  = l;
    in_valid4 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready4) begin
        cyc();
        ok = 1;
        break;
      end
      cyc();
    end
    in_valid4 = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send4_timeout: got in_ready=0 expected 1");
    end
  endtask

  task automatic get4(string nm, logic [15:0] e, logic es);
    int n = 0;
    while (!out_valid4 && n < 40) begin
      cyc();
      n++;
    end
    if (!out_valid4) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got out_valid=0 expected 1", nm);
    end else begin
      chk({nm, "_data"}, 32'(out_data4), 32'(e));
      chk({nm, "_sat"}, 32'(out_sat4), 32'(es));
    end
    out_ready4 = 1'b1;
    cyc();
    out_ready4 = 1'b0;
    chk({nm, "_drop"}, 32'(out_valid4), 32'd0);
  endtask

  task automatic run2(string nm, logic [31:0] d,
                      logic [15:0] e, logic es);
    int n = 0;
    in_data2  = d;
    in_last2  = 1'b1;
    in_valid2 = 1'b1;
    while (!in_ready2 && n < 20) begin
      cyc();
      n++;
    end
    cyc();
    in_valid2 = 1'b0;
    n = 0;
    while (!out_valid2 && n < 20) begin
      cyc();
      n++;
    end
    if (!out_valid2) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got out_valid=0 expected 1", nm);
    end else begin
      chk({nm, "_data"}, 32'(out_data2), 32'(e));
      chk({nm, "_sat"}, 32'(out_sat2), 32'(es));
    end
    out_ready2 = 1'b1;
    cyc();
    out_ready2 = 1'b0;
  endtask

  initial begin
    logic [15:0] held_d;
    logic        bad;

    tbl[0] = '{64'h0400_0400_0400_0400, 1'b1, 16'h0C00, 1'b0};
    tbl[1] = '{64'h0000_0000_8400_0800, 1'b0, 16'h0000, 1'b0};
    tbl[2] = '{64'h0000_0000_0000_0000, 1'b1, 16'h0C80, 1'b0};
    tbl[3] = '{64'h8400_8400_8400_8400, 1'b1, 16'h8C00, 1'b0};
    tbl[4] = '{64'h0000_0400_8400_0400, 1'b1, 16'h0800, 1'b0};
    tbl[5] = '{64'h0000_0000_0000_2800, 1'b1, 16'h2803, 1'b0};
    tbl[6] = '{64'h0000_0000_0000_7C00, 1'b1, 16'h7C00, 1'b0};
    tbl[7] = '{64'h0000_0000_7F00_7F00, 1'b1, 16'h7FFF, 1'b1};
    tbl[8] = '{64'h0400_0400_0400_0400, 1'b1, 16'h0C00, 1'b0};

    reset      = 1'b1;
    in_data4   = '0;
    in_valid4  = 1'b0;
    in_last4   = 1'b0;
    out_ready4 = 1'b0;
    in_data2   = '0;
    in_valid2  = 1'b0;
    in_last2   = 1'b0;
    out_ready2 = 1'b0;
    cyc();
    cyc();
    chk("rst_in_ready", 32'(in_ready4), 32'd1);
    chk("rst_out_valid", 32'(out_valid4), 32'd0);
    chk("rst_out_data", 32'(out_data4), 32'd0);
    chk("rst_out_sat", 32'(out_sat4), 32'd0);
    reset = 1'b0;
    cyc();

    for (int i = 0; i < 9; i++) begin
      send4(tbl[i].data, tbl[i].last);
      if (tbl[i].last) begin
        get4($sformatf("vec%0d", i), tbl[i].exp, tbl[i].esat);
      end
    end

    // latency, and in_data changes after the handshake are ignored
    send4(64'h0400_0400_0400_0400, 1'b1);
    in_data4 = 64'h1234_5678_9ABC_DEF0;
    chk("lat_busy", 32'(in_ready4), 32'd0);
    cyc();
    cyc();
    cyc();
    chk("lat_early", 32'(out_valid4), 32'd0);
    cyc();
    chk("lat_valid", 32'(out_valid4), 32'd1);
    get4("lat", 16'h0C00, 1'b0);

    // backpressure: output held stable, extra beats refused
    send4(64'h0400_0400_0400_0400, 1'b1);
    for (int i = 0; i < 10 && !out_valid4; i++) cyc();
    held_d    = out_data4;
    in_data4  = 64'h0800_0800_0800_0800;
    in_last4  = 1'b1;
    in_valid4 = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (!out_valid4 || in_ready4 || out_data4 !== 16'h0C00) bad = 1'b1;
    end
    chk("bp_stable", 32'(bad), 32'd0);
    chk("bp_held", 32'(held_d), 32'h0C00);
    in_valid4 = 1'b0;
    get4("bp", 16'h0C00, 1'b0);
    chk("bp_idle", 32'(in_ready4), 32'd1);
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (out_valid4) bad = 1'b1;
    end
    chk("bp_no_extra", 32'(bad), 32'd0);

    // reset while folding lane 2
    send4(64'h0400_0400_0400_0400, 1'b1);
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mid_rst_valid", 32'(out_valid4), 32'd0);
    chk("mid_rst_ready", 32'(in_ready4), 32'd1);
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (out_valid4) bad = 1'b1;
    end
    chk("mid_rst_quiet", 32'(bad), 32'd0);
    send4(64'h0400_0400_0400_0400, 1'b1);
    get4("post_rst", 16'h0C00, 1'b0);

    // z=2 cancel, saturate, then sat cleared on the next vector
    run2("z2_cancel", 32'h8100_0100, 16'h0000, 1'b0);
    run2("z2_sat", 32'h7F00_7F00, 16'h7FFF, 1'b1);
    run2("z2_clr", 32'h0400_0400, 16'h0800, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
